// File: rtl/matrix_multiplier_sequencer.sv
// matrix_multiplier_sequencer
//   Streaming front/back end for the matrix_multiplier datapath. A then B
//   elements arrive serially (row-major) on a valid/ready stream and are
//   presented in parallel to the multiplier, which is then fired once. The
//   C result is captured at full width and streamed out row-major with
//   valid/ready and a last marker.
//
// Ports
//   clk_i, reset_ni           clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o     input element handshake, in_data_i = A/B element
//   out_valid_o/out_ready_i   output element handshake, out_data_o = C element
//   out_last_o                high with the final C element
//   busy_o                    high unless idle in LOAD with nothing loaded
//   mm_valid_o, mm_a_o, mm_b_o   to the multiplier (valid_i, a_i, b_i)
//   mm_valid_i, mm_c_i        from the multiplier (valid_o, c_o)
//   timeout_o                 one-cycle pulse when the WAIT watchdog expires
//
// Build option
//   MM_SEQ_TIMEOUT_EN  enables the WAIT-state watchdog (TIMEOUT_CYCLES);
//                      when undefined WAIT is unbounded and timeout_o is 0.

module matrix_multiplier_sequencer #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned A_ROWS           = 8,
    parameter int unsigned B_COLUMNS        = 5,
    parameter int unsigned A_COLUMNS_B_ROWS = 4,
    parameter int unsigned C_DATA_WIDTH     = 2 * DATA_WIDTH + $clog2(A_COLUMNS_B_ROWS),
    parameter int unsigned TIMEOUT_CYCLES   = 16
) (
    input  logic                                              clk_i,
    input  logic                                              reset_ni,
    input  logic                                              in_valid_i,
    output logic                                              in_ready_o,
    input  logic [DATA_WIDTH-1:0]                             in_data_i,
    output logic                                              out_valid_o,
    input  logic                                              out_ready_i,
    output logic [C_DATA_WIDTH-1:0]                           out_data_o,
    output logic                                              out_last_o,
    output logic                                              busy_o,
    output logic                                              mm_valid_o,
    output logic [DATA_WIDTH*A_ROWS*A_COLUMNS_B_ROWS-1:0]     mm_a_o,
    output logic [DATA_WIDTH*A_COLUMNS_B_ROWS*B_COLUMNS-1:0]  mm_b_o,
    input  logic                                              mm_valid_i,
    input  logic [C_DATA_WIDTH*A_ROWS*B_COLUMNS-1:0]          mm_c_i,
    output logic                                              timeout_o
);

    localparam int unsigned NA     = A_ROWS * A_COLUMNS_B_ROWS;
    localparam int unsigned NB     = A_COLUMNS_B_ROWS * B_COLUMNS;
    localparam int unsigned NC     = A_ROWS * B_COLUMNS;
    localparam int unsigned LOAD_W = $clog2(NA + NB);
    localparam int unsigned OUT_W  = (NC > 1) ? $clog2(NC) : 1;

    // Watchdog must allow at least one full multiplier round trip
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {ST_LOAD, ST_FIRE, ST_WAIT, ST_DRAIN} state_e;

    state_e                    state_q, state_d;
    logic [LOAD_W-1:0]         load_cnt_q, load_cnt_d;
    logic [OUT_W-1:0]          out_cnt_q, out_cnt_d;
    logic [C_DATA_WIDTH-1:0]   out_data_d;
    logic                      ab_we;
    logic                      c_we;
    logic [DATA_WIDTH-1:0]     ab_q [NA+NB];
    logic [C_DATA_WIDTH-1:0]   c_q  [NC];

`ifdef MM_SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic                      timeout_d;
`else
    assign timeout_o = 1'b0;
`endif

    // Multiplier operands come straight from the element store
    always_comb begin
        for (int unsigned i = 0; i < NA; i++) begin
            mm_a_o[i*DATA_WIDTH +: DATA_WIDTH] = ab_q[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NB; i++) begin
            mm_b_o[i*DATA_WIDTH +: DATA_WIDTH] = ab_q[NA+i];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        out_cnt_d  = out_cnt_q;
        out_data_d = out_data_o;
        ab_we      = 1'b0;
        c_we       = 1'b0;
`ifdef MM_SEQ_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            ST_LOAD: begin
                if (in_valid_i && in_ready_o) begin
                    ab_we = 1'b1;
                    if (load_cnt_q == LOAD_W'(NA + NB - 1)) begin
                        load_cnt_d = '0;
                        state_d    = ST_FIRE;
                    end else begin
                        load_cnt_d = load_cnt_q + LOAD_W'(1);
                    end
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
`ifdef MM_SEQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
`ifdef MM_SEQ_TIMEOUT_EN
                // Expired frame: timeout_o is high this cycle, drop everything
                if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES)) begin
                    wait_cnt_d = '0;
                    load_cnt_d = '0;
                    out_cnt_d  = '0;
                    state_d    = ST_LOAD;
                end else
`endif
                if (mm_valid_i) begin
                    c_we       = 1'b1;
                    out_cnt_d  = '0;
                    out_data_d = mm_c_i[C_DATA_WIDTH-1:0];
                    state_d    = ST_DRAIN;
                end
`ifdef MM_SEQ_TIMEOUT_EN
                else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    timeout_d  = (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
                end
`endif
            end
            ST_DRAIN: begin
                if (out_valid_o && out_ready_i) begin
                    if (out_cnt_q == OUT_W'(NC - 1)) begin
                        out_cnt_d  = '0;
                        load_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        out_cnt_d  = out_cnt_q + OUT_W'(1);
                        out_data_d = c_q[out_cnt_q + OUT_W'(1)];
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State, storage and registered outputs
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            out_cnt_q   <= '0;
            in_ready_o  <= 1'b0;
            mm_valid_o  <= 1'b0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            out_data_o  <= '0;
            for (int unsigned i = 0; i < NA + NB; i++) ab_q[i] <= '0;
            for (int unsigned j = 0; j < NC; j++) c_q[j] <= '0;
`ifdef MM_SEQ_TIMEOUT_EN
            wait_cnt_q  <= '0;
            timeout_o   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            out_cnt_q   <= out_cnt_d;
            in_ready_o  <= (state_d == ST_LOAD);
            mm_valid_o  <= (state_d == ST_FIRE);
            out_valid_o <= (state_d == ST_DRAIN);
            out_last_o  <= (state_d == ST_DRAIN) && (out_cnt_d == OUT_W'(NC - 1));
            busy_o      <= !((state_d == ST_LOAD) && (load_cnt_d == '0));
            out_data_o  <= out_data_d;
            if (ab_we) ab_q[load_cnt_q] <= in_data_i;
            if (c_we) begin
                for (int unsigned j = 0; j < NC; j++) begin
                    c_q[j] <= mm_c_i[j*C_DATA_WIDTH +: C_DATA_WIDTH];
                end
            end
`ifdef MM_SEQ_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            timeout_o   <= timeout_d;
`endif
        end
    end

endmodule
